// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter: packet layout,
// core-wide index widths and the functional-unit identifiers.
package cdb_arbiter_pkg;

  localparam int N_FU_CFG = 4;
  localparam int ROB_IDX  = 5;
  localparam int PRF_IDX  = 6;
  localparam int ARF_IDX  = 5;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_BR  = 2'd3
  } fu_id_e;

  typedef struct packed {
    logic [ROB_IDX-1:0] rob_id;
    logic [PRF_IDX-1:0] rd_phy;
    logic [ARF_IDX-1:0] rd_arch;
    logic [31:0]        rd_value;
    logic [31:0]        rs1_value_dbg;
    logic [31:0]        rs2_value_dbg;
  } cdb_pkt_t;

  // Round-robin successor of an FU index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports and CDB broadcast bundle. The master side is the FU/backend
// world, the slave side is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU = N_FU_CFG
);

  logic                          flush;
  logic [N_FU-1:0]               fu_valid;
  logic [N_FU-1:0]               fu_ready;
  cdb_pkt_t [N_FU-1:0]           fu_pkt;

  logic                          cdb_valid;
  logic [ROB_IDX-1:0]            cdb_rob_id;
  logic [PRF_IDX-1:0]            cdb_rd_phy;
  logic [ARF_IDX-1:0]            cdb_rd_arch;
  logic [31:0]                   cdb_rd_value;
  logic [31:0]                   cdb_rs1_value_dbg;
  logic [31:0]                   cdb_rs2_value_dbg;

  modport master (
    output flush, fu_valid, fu_pkt,
    input  fu_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
           cdb_rd_value, cdb_rs1_value_dbg, cdb_rs2_value_dbg
  );

  modport slave (
    input  flush, fu_valid, fu_pkt,
    output fu_ready, cdb_valid, cdb_rob_id, cdb_rd_phy, cdb_rd_arch,
           cdb_rd_value, cdb_rs1_value_dbg, cdb_rs2_value_dbg
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr,
// wrapping around, wins. The request vector is doubled so the wrap becomes a
// plain linear scan over a window of N bits starting at ptr.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [2*N-1:0] req2;

  assign req2 = {req_i, req_i};

  // Priority scan over the window [ptr, ptr+N) of the doubled request vector.
  always_comb begin
    logic found;
    int   w;
    found     = 1'b0;
    w         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (en_i && !found && (k >= int'(ptr_i)) && (k < int'(ptr_i) + N) && req2[k]) begin
        found     = 1'b1;
        w         = (k >= N) ? k - N : k;
        gnt_idx_o = IDX_W'(w);
        gnt_o     = {{(N-1){1'b0}}, 1'b1} << w;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one FU result per cycle round-robin and
// broadcasts the accepted packet on the CDB exactly one cycle later. Flush
// blocks grants, so nothing accepted in a flush cycle reaches the bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_FU = N_FU_CFG
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_FU-1:0]  gnt;
  logic             grant_en;
  logic             xfer;
  logic             cdb_valid_q;
  cdb_pkt_t         cdb_pkt_q, cdb_pkt_d;

  // No grant while in reset or flushing; the FU simply keeps holding.
  assign grant_en = rst_n & ~bus.flush;

  rr_arbiter #(.N(N_FU)) u_rr (
    .req_i     (bus.fu_valid),
    .ptr_i     (ptr_q),
    .en_i      (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign xfer         = |gnt;
  assign bus.fu_ready = gnt;

  // Pointer moves just past the winner; payload captures the winner's packet.
  always_comb begin
    ptr_d     = ptr_q;
    cdb_pkt_d = cdb_pkt_q;
    if (xfer) begin
      ptr_d     = PTR_W'(wrap_inc(int'(gnt_idx), N_FU));
      cdb_pkt_d = bus.fu_pkt[gnt_idx];
    end
  end

  // Pointer and broadcast register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= xfer;
      cdb_pkt_q   <= cdb_pkt_d;
    end
  end

  assign bus.cdb_valid         = cdb_valid_q;
  assign bus.cdb_rob_id        = cdb_pkt_q.rob_id;
  assign bus.cdb_rd_phy        = cdb_pkt_q.rd_phy;
  assign bus.cdb_rd_arch       = cdb_pkt_q.rd_arch;
  assign bus.cdb_rd_value      = cdb_pkt_q.rd_value;
  assign bus.cdb_rs1_value_dbg = cdb_pkt_q.rs1_value_dbg;
  assign bus.cdb_rs2_value_dbg = cdb_pkt_q.rs2_value_dbg;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.fu_ready));
  a_ready_valid:  assert property (@(posedge clk) (bus.fu_ready & ~bus.fu_valid) == '0);
  a_flush_kill:   assert property (@(posedge clk) bus.flush |=> !bus.cdb_valid);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized holding FUs,
// checked against a rotation-order reference model and per-FU scoreboard.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_FU(N)) bus ();

  cdb_arbiter #(.N_FU(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_ptr;
  bit       m_vld;
  cdb_pkt_t m_pkt;
  bit       m_prev_flush;

  // last observation, for directed expectations
  logic [N-1:0]       last_rdy;
  logic               last_vld;
  logic [ROB_IDX-1:0] last_rob;

  // random-phase FU and scoreboard state
  bit       sb_on;
  bit       pend [N];
  int       wait_cnt [N];
  cdb_pkt_t pend_pkt [N];
  cdb_pkt_t acc_q [N][$];
  int       seq;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cdb_pkt_t mk_pkt(input int fu, input int s);
    cdb_pkt_t p;
    p.rob_id        = ROB_IDX'($urandom);
    p.rd_phy        = PRF_IDX'($urandom);
    p.rd_arch       = ARF_IDX'($urandom);
    p.rd_value      = {8'(fu), 24'(s)};
    p.rs1_value_dbg = $urandom;
    p.rs2_value_dbg = $urandom;
    return p;
  endfunction

  // One clock: sample and check mid-cycle, then advance the model past the edge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    int           win;
    int           fu;
    int           n;
    cdb_pkt_t     obs;
    bit           nx_vld;
    int           nx_ptr;
    cdb_pkt_t     nx_pkt;
    #2;
    exp_rdy = '0;
    win     = -1;
    if (rst_n && !bus.flush) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (win < 0 && bus.fu_valid[idx]) begin
          win          = idx;
          exp_rdy[idx] = 1'b1;
        end
      end
    end
    obs = {bus.cdb_rob_id, bus.cdb_rd_phy, bus.cdb_rd_arch, bus.cdb_rd_value,
           bus.cdb_rs1_value_dbg, bus.cdb_rs2_value_dbg};
    last_rdy = bus.fu_ready;
    last_vld = bus.cdb_valid;
    last_rob = bus.cdb_rob_id;
    chk("fu_ready", 128'(bus.fu_ready), 128'(exp_rdy));
    chk("cdb_valid", 128'(bus.cdb_valid), 128'(m_vld));
    chk("cdb_payload", 128'(obs), 128'(m_pkt));
    chk("ready_onehot0", 128'($onehot0(bus.fu_ready)), 128'(1));
    chk("ready_implies_valid", 128'(bus.fu_ready & ~bus.fu_valid), 128'(0));
    if (m_prev_flush) chk("flush_kill", 128'(bus.cdb_valid), 128'(0));

    if (sb_on) begin
      if (bus.cdb_valid) begin
        fu = int'(bus.cdb_rd_value[31:24]);
        n  = (fu < N) ? acc_q[fu].size() : 0;
        chk("sb_have_pkt", 128'(n != 0), 128'(1));
        if (n != 0) chk("sb_order", 128'(obs), 128'(acc_q[fu].pop_front()));
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i] && !bus.flush) wait_cnt[i]++;
        if (bus.fu_valid[i] && bus.fu_ready[i]) begin
          acc_q[i].push_back(pend_pkt[i]);
          chk("max_wait", 128'(wait_cnt[i] <= N), 128'(1));
          pend[i] = 1'b0;
        end
      end
    end

    nx_ptr = m_ptr;
    nx_pkt = m_pkt;
    nx_vld = 1'b0;
    if (!rst_n) begin
      nx_ptr = 0;
      nx_pkt = '0;
    end else if (win >= 0) begin
      nx_ptr = (win + 1) % N;
      nx_pkt = bus.fu_pkt[win];
      nx_vld = 1'b1;
    end
    m_prev_flush = bus.flush;
    @(posedge clk);
    #1;
    m_ptr = nx_ptr;
    m_pkt = nx_pkt;
    m_vld = nx_vld;
  endtask

  initial begin
    cdb_pkt_t p;
    int       total;
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.fu_valid = '0;
    sb_on        = 1'b0;
    seq          = 0;
    for (int i = 0; i < N; i++) begin
      bus.fu_pkt[i] = mk_pkt(i, 0);
      pend[i]       = 1'b0;
      wait_cnt[i]   = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    m_ptr = 0; m_vld = 1'b0; m_pkt = '0; m_prev_flush = 1'b0;

    // reset held with every FU requesting
    bus.fu_valid = 4'b1111;
    repeat (3) begin
      tick();
      chk("rst_ready", 128'(last_rdy), 128'(0));
      chk("rst_cdb_valid", 128'(last_vld), 128'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("rst_first_grant", 128'(last_rdy), 128'(4'b0001));

    // single requester, back-to-back
    bus.fu_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      p        = mk_pkt(2, k);
      p.rob_id = ROB_IDX'(3 + k);
      bus.fu_pkt[2] = p;
      tick();
      chk("single_ready", 128'(last_rdy), 128'(4'b0100));
      if (k > 0) begin
        chk("single_cdb_valid", 128'(last_vld), 128'(1));
        chk("single_rob", 128'(last_rob), 128'(3 + k - 1));
      end
    end
    bus.fu_valid = '0;
    tick();
    chk("single_rob_last", 128'(last_rob), 128'(7));

    // all valid from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.fu_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("allv_order", 128'(last_rdy), 128'(1 << (k % 4)));
    end

    // pointer skip and wrap
    bus.fu_valid = 4'b0100;
    tick();
    bus.fu_valid = 4'b0011;
    tick();
    chk("wrap_fu0", 128'(last_rdy), 128'(4'b0001));
    tick();
    chk("wrap_fu1", 128'(last_rdy), 128'(4'b0010));

    // flush blocks the grant for one cycle, then arbitration resumes
    bus.fu_valid = 4'b1010;
    bus.flush    = 1'b1;
    tick();
    chk("flush_ready", 128'(last_rdy), 128'(0));
    bus.flush = 1'b0;
    tick();
    chk("flush_resume", 128'(last_rdy), 128'(4'b1000));
    chk("flush_no_bcast", 128'(last_vld), 128'(0));

    // reset mid-stream
    bus.fu_valid = 4'b1111;
    rst_n = 1'b0;
    tick();
    chk("midrst_ready", 128'(last_rdy), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("midrst_grant0", 128'(last_rdy), 128'(4'b0001));
    chk("midrst_no_vld", 128'(last_vld), 128'(0));
    bus.fu_valid = '0;
    tick();
    tick();

    // randomized holding FUs with occasional flush
    sb_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          seq++;
          pend[i]     = 1'b1;
          wait_cnt[i] = 0;
          pend_pkt[i] = mk_pkt(i, seq);
        end
        bus.fu_valid[i] = pend[i];
        bus.fu_pkt[i]   = pend_pkt[i];
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.fu_valid = '0;
    bus.flush    = 1'b0;
    tick();
    tick();
    total = 0;
    for (int i = 0; i < N; i++) total += acc_q[i].size();
    chk("sb_drain", 128'(total), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N_FU functional-unit result ports (ALU, MUL, DIV, branch, ...).
- Each cycle it round-robin grants at most one requesting FU and registers that FU's result packet.
- The packet is broadcast one cycle later on the CDB outputs, which drive the RS wakeup, PRF write, ROB completion and RAT valid-bit update.
- A flush input suppresses grants and kills any in-flight broadcast.

Parameters:
- N_FU, 4, number of requesting functional units (≥2).
- ROB_IDX, PRF_IDX and ARF_IDX are cpu_params package constants, not module parameters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  backend flush; kill current grant and broadcast
- fu_valid  in  N_FU  FU i has a completed result
- fu_ready  out  N_FU  FU i's result accepted this cycle (one-hot or zero)
- fu_pkt  in  N_FU x cdb_pkt_t  per-FU {rob_id, rd_phy, rd_arch, rd_value, rs1_value_dbg, rs2_value_dbg}
- cdb_valid  out  1  broadcast valid
- cdb_rob_id  out  ROB_IDX  ROB entry completed
- cdb_rd_phy  out  PRF_IDX  destination physical register
- cdb_rd_arch  out  ARF_IDX  destination architectural register
- cdb_rd_value  out  32  result value
- cdb_rs1_value_dbg  out  32  RVFI debug operand 1
- cdb_rs2_value_dbg  out  32  RVFI debug operand 2

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at posedge):
  - cdb_valid=0, all cdb_* payload=0, priority pointer ptr=0.
  - fu_ready=0 combinationally while rst_n=0.
- Grant (combinational):
  - Search fu_valid starting at index ptr, wrapping modulo N_FU; the first set bit wins.
  - fu_ready = one-hot(winner) if any valid and !flush and rst_n; otherwise 0.
  - Transfer occurs when fu_valid[i] && fu_ready[i].
  - fu_ready depends combinationally on fu_valid. FUs must not derive fu_valid from fu_ready (no loop).
- FU contract: an FU holds fu_valid and a stable fu_pkt until accepted; the arbiter never buffers an unaccepted packet.
- Pointer update: on a transfer from FU i, ptr <= (i+1) mod N_FU. With no transfer, ptr holds. Flush does not reset ptr.
- Broadcast register (latency exactly 1 cycle from accept):
  - Transfer cycle: cdb_* payload <= fu_pkt[i], cdb_valid <= 1.
  - No transfer: cdb_valid <= 0; payload holds its last value (don't-care when invalid).
- Throughput: one result per cycle, sustained. No bubble between back-to-back grants.
- Fairness: a continuously-valid FU is granted within N_FU cycles.
- Flush:
  - In the flush cycle: fu_ready=0, and cdb_valid <= 0 at the next edge.
  - A broadcast already registered before flush appears for its cycle; downstream ignores it under flush.
- Reset mid-stream:
  - Pending FU requests are not accepted.
  - After rst_n rises, arbitration restarts from ptr=0 with no residual cdb_valid.
- rd_arch==0 / rd_phy==0 results are broadcast unchanged; consumers handle x0.
- Single valid requester: granted every cycle it is valid, regardless of ptr.
- All-valid case: grants rotate ptr, ptr+1, ..., wrapping from N_FU-1 to 0.
- Assertions (bench and RTL):
  - $onehot0(fu_ready).
  - fu_ready[i] implies fu_valid[i].
  - cdb_valid is never 1 in the cycle after a flush.

Decomposition:
- Package: cdb_pkt_t struct {rob_id[ROB_IDX], rd_phy[PRF_IDX], rd_arch[ARF_IDX], rd_value[32], rs1_value_dbg[32], rs2_value_dbg[32]} goes in the shared uop_types package, so FUs and the CDB interface agree on layout.
- N_FU and FU index enum (FU_ALU, FU_MUL, FU_DIV, FU_BR) go in cpu_params.
- Sub-module rr_arbiter (N param):
  - Inputs: req[N], ptr, en.
  - Outputs: gnt[N] one-hot, gnt_idx.
  - Purely combinational double-width priority search.
  - cdb_arbiter owns ptr, the payload mux and the broadcast register.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with fu_valid=4'b1111 -> fu_ready=0 and cdb_valid=0 throughout; first cycle after release grants FU0 (ptr=0).
- Single requester: fu_valid=4'b0100 for 5 cycles with rob_id=3..7 -> fu_ready=4'b0100 each cycle; cdb_valid=1 and cdb_rob_id=3..7 starting 1 cycle after each accept, no bubbles.
- All valid, held: fu_valid=4'b1111 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each FU's packet appears on CDB exactly 1 cycle after its grant.
- Pointer skip/wrap: ptr=3 after granting FU2, then fu_valid=4'b0011 -> FU0 granted, ptr=1; next cycle FU1 granted, ptr=2.
- Flush: fu_valid=4'b1010 with flush=1 for one cycle -> fu_ready=0 and next-cycle cdb_valid=0; in the following cycle (flush=0, ptr unchanged) the arbiter resumes granting.
- Random stress: 10k cycles of random valid with FUs holding until accepted -> scoreboard shows every packet broadcast exactly once, in per-FU order, max wait ≤4 cycles, and assertions never fire.
